// File: rtl/fft_package.sv
// Shared types and address helper for the radix-2 DIT FFT stage scheduler.
package fft_package;

    localparam int unsigned MAX_LOG2_N = 10;
    localparam int unsigned MAX_K_W    = MAX_LOG2_N - 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FINISH
    } sched_state_t;

    typedef struct packed {
        logic                  valid;
        logic [MAX_LOG2_N-1:0] top;
        logic [MAX_LOG2_N-1:0] bottom;
    } wb_entry_t;

    typedef struct packed {
        logic [MAX_LOG2_N-1:0] top;
        logic [MAX_LOG2_N-1:0] bottom;
        logic [MAX_K_W-1:0]    tw;
    } bfly_addr_t;

    // Butterfly k of stage s: top/bottom operand addresses and twiddle index.
    function automatic bfly_addr_t bfly_addr(input logic [3:0]         s,
                                             input logic [MAX_K_W-1:0] k,
                                             input logic [3:0]         log2_n);
        logic [MAX_LOG2_N-1:0] half;
        logic [MAX_LOG2_N-1:0] j;
        bfly_addr_t            r;
        half     = 10'd1 << s;
        j        = {1'b0, k} & (half - 10'd1);
        r.top    = (({1'b0, k} >> s) << (s + 4'd1)) | j;
        r.bottom = r.top + half;
        r.tw     = j[MAX_K_W-1:0] << (log2_n - 4'd1 - s);
        return r;
    endfunction

endpackage

// File: rtl/wb_delay_line.sv
// Fixed-latency shift register with synchronous clear; aligns write-back with reads.
module wb_delay_line #(
    parameter int unsigned DEPTH = 6,
    parameter int unsigned WIDTH = 21
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] taps [DEPTH];

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                taps[i] <= '0;
            end
        end else begin
            taps[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign dout = taps[DEPTH-1];

endmodule

// File: rtl/fft_stage_sched.sv
// Address sequencer for one shared radix-2 butterfly running an in-place DIT FFT.
// Optional FFT_SCHED_CYCLE_CNT_EN adds the last_cycles transform-length counter.
module fft_stage_sched
    import fft_package::*;
#(
    parameter int unsigned LOG2_N   = 5,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned PIPE_LAT = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       rd_en,
    output logic [LOG2_N-1:0]          rd_addr_a,
    output logic [LOG2_N-1:0]          rd_addr_b,
    output logic [LOG2_N-2:0]          tw_addr,
    output logic [$clog2(LOG2_N)-1:0]  stage,
    output logic                       stage0,
    output logic                       wr_en,
    output logic [LOG2_N-1:0]          wr_addr_a,
    output logic [LOG2_N-1:0]          wr_addr_b
`ifdef FFT_SCHED_CYCLE_CNT_EN
    ,
    output logic [15:0]                last_cycles
`endif
);

    localparam int unsigned TOTAL_LAT = RD_LAT + PIPE_LAT;
    localparam int unsigned SW        = $clog2(LOG2_N);
    localparam int unsigned KW        = LOG2_N - 1;
    localparam int unsigned CW        = $clog2(TOTAL_LAT) + 1;
    localparam int unsigned WB_W      = $bits(wb_entry_t);

    localparam logic [SW-1:0] LAST_STAGE = SW'(LOG2_N - 1);
    localparam logic [KW-1:0] LAST_K     = '1;
    localparam logic [CW-1:0] LAST_DRAIN = CW'(TOTAL_LAT - 1);

    sched_state_t  state;
    logic [KW-1:0] k_q;
    logic [KW-1:0] nxt_k;
    logic [SW-1:0] nxt_s;
    logic [CW-1:0] drain_cnt;
    logic          accept;
    logic          drain_end;
    logic          finish_go;
    bfly_addr_t    nxt_addr;
    wb_entry_t     wb_in;
    wb_entry_t     wb_out;
    logic          unused_bits;

    assign accept    = (state == IDLE) && start;
    assign drain_end = (state == DRAIN) && (drain_cnt == LAST_DRAIN);
    assign finish_go = drain_end && (stage == LAST_STAGE);

    // Address of the next butterfly to be issued, whichever transition takes it.
    always_comb begin
        nxt_s = stage;
        nxt_k = k_q + 1'b1;
        if (state == IDLE) begin
            nxt_s = '0;
            nxt_k = '0;
        end else if (state == DRAIN) begin
            nxt_s = stage + 1'b1;
            nxt_k = '0;
        end
        nxt_addr = bfly_addr(4'(nxt_s), MAX_K_W'(nxt_k), 4'(LOG2_N));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            k_q       <= '0;
            drain_cnt <= '0;
            stage     <= '0;
            stage0    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_addr   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= ISSUE;
                        stage     <= nxt_s;
                        k_q       <= nxt_k;
                        stage0    <= 1'b1;
                        busy      <= 1'b1;
                        rd_en     <= 1'b1;
                        rd_addr_a <= nxt_addr.top[LOG2_N-1:0];
                        rd_addr_b <= nxt_addr.bottom[LOG2_N-1:0];
                        tw_addr   <= nxt_addr.tw[LOG2_N-2:0];
                    end
                end
                ISSUE: begin
                    if (k_q == LAST_K) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                        rd_en     <= 1'b0;
                        stage0    <= 1'b0;
                    end else begin
                        k_q       <= nxt_k;
                        rd_addr_a <= nxt_addr.top[LOG2_N-1:0];
                        rd_addr_b <= nxt_addr.bottom[LOG2_N-1:0];
                        tw_addr   <= nxt_addr.tw[LOG2_N-2:0];
                    end
                end
                DRAIN: begin
                    // Holding here until the last write lands avoids read-after-write hazards.
                    if (drain_cnt == LAST_DRAIN) begin
                        if (stage == LAST_STAGE) begin
                            state <= FINISH;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state     <= ISSUE;
                            stage     <= nxt_s;
                            k_q       <= nxt_k;
                            rd_en     <= 1'b1;
                            rd_addr_a <= nxt_addr.top[LOG2_N-1:0];
                            rd_addr_b <= nxt_addr.bottom[LOG2_N-1:0];
                            tw_addr   <= nxt_addr.tw[LOG2_N-2:0];
                        end
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign wb_in = '{
        valid:  rd_en,
        top:    MAX_LOG2_N'(rd_addr_a),
        bottom: MAX_LOG2_N'(rd_addr_b)
    };

    wb_delay_line #(
        .DEPTH (TOTAL_LAT),
        .WIDTH (WB_W)
    ) u_wb_delay (
        .clk   (clk),
        .clear (reset),
        .din   (wb_in),
        .dout  (wb_out)
    );

    assign wr_en     = wb_out.valid;
    assign wr_addr_a = wb_out.top[LOG2_N-1:0];
    assign wr_addr_b = wb_out.bottom[LOG2_N-1:0];

    assign unused_bits = ^{wb_out, nxt_addr, accept, drain_end, finish_go};

`ifdef FFT_SCHED_CYCLE_CNT_EN
    logic [15:0] cyc_cnt;

    // cyc_cnt equals the cycle index (start cycle = 0) during a run.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_cnt     <= '0;
            last_cycles <= '0;
        end else begin
            if (accept) begin
                cyc_cnt <= 16'd1;
            end else if (busy && cyc_cnt != 16'hFFFF) begin
                cyc_cnt <= cyc_cnt + 16'd1;
            end
            if (finish_go) begin
                last_cycles <= (cyc_cnt == 16'hFFFF) ? cyc_cnt : cyc_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fft_stage_sched.sv
// Scoreboard bench for fft_stage_sched at N=32, RD_LAT=1, PIPE_LAT=5.
module tb_fft_stage_sched;

    localparam int LOG2_N    = 5;
    localparam int N         = 32;
    localparam int TOTAL_LAT = 6;
    localparam int P         = N / 2 + TOTAL_LAT;
    localparam int DONE_AT   = LOG2_N * P + 1;

    typedef struct {
        int cyc;
        int a;
        int b;
        int tw;
        int s;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       busy;
    logic       done;
    logic       rd_en;
    logic [4:0] rd_addr_a;
    logic [4:0] rd_addr_b;
    logic [3:0] tw_addr;
    logic [2:0] stage;
    logic       stage0;
    logic       wr_en;
    logic [4:0] wr_addr_a;
    logic [4:0] wr_addr_b;
`ifdef FFT_SCHED_CYCLE_CNT_EN
    logic [15:0] last_cycles;
`endif

    exp_t rd_q[$];
    exp_t wr_q[$];
    int   done_q[$];
    exp_t e;
    int   d;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   t0;

    // {cycle, top, bottom, tw} taken by hand from the butterfly tables
    int dir_tab [5][4] = '{
        '{1, 0, 1, 0},
        '{2, 2, 3, 0},
        '{3, 4, 5, 0},
        '{50, 9, 13, 4},
        '{104, 15, 31, 15}
    };

    fft_stage_sched #(
        .LOG2_N   (LOG2_N),
        .RD_LAT   (1),
        .PIPE_LAT (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_addr   (tw_addr),
        .stage     (stage),
        .stage0    (stage0),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b)
`ifdef FFT_SCHED_CYCLE_CNT_EN
        ,
        .last_cycles (last_cycles)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Expected reads, writes and done for a transform whose start is seen in cycle t.
    task automatic push_run(input int t);
        int half;
        int grp;
        int k;
        int top;
        int rc;
        for (int s = 0; s < LOG2_N; s++) begin
            half = 1 << s;
            grp  = N / (2 * half);
            for (int g = 0; g < grp; g++) begin
                for (int j = 0; j < half; j++) begin
                    k   = g * half + j;
                    top = g * 2 * half + j;
                    rc  = t + s * P + 1 + k;
                    rd_q.push_back('{rc, top, top + half, j * grp, s});
                    wr_q.push_back('{rc + TOTAL_LAT, top, top + half, 0, s});
                end
            end
        end
        done_q.push_back(t + DONE_AT);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {rd_en, rd_addr_a, rd_addr_b, tw_addr, stage, stage0,
                     wr_en, wr_addr_a, wr_addr_b, busy, done}, 32'd0);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (rd_en) begin
                check("rd_expected", 32'(rd_q.size() > 0), 32'd1);
                if (rd_q.size() > 0) begin
                    e = rd_q.pop_front();
                    check("rd_cycle", cyc, e.cyc);
                    check("rd_addr", 32'({rd_addr_a, rd_addr_b, tw_addr, stage, stage0, busy}),
                          32'({5'(e.a), 5'(e.b), 4'(e.tw), 3'(e.s), (e.s == 0), 1'b1}));
                end
            end
            if (wr_en) begin
                check("wr_expected", 32'(wr_q.size() > 0), 32'd1);
                if (wr_q.size() > 0) begin
                    e = wr_q.pop_front();
                    check("wr_cycle", cyc, e.cyc);
                    check("wr_addr", 32'({wr_addr_a, wr_addr_b}), 32'({5'(e.a), 5'(e.b)}));
                end
            end
            if (done) begin
                check("done_expected", 32'(done_q.size() > 0), 32'd1);
                if (done_q.size() > 0) begin
                    d = done_q.pop_front();
                    check("done_cycle", cyc, d);
                    check("done_busy", 32'(busy), 32'd0);
`ifdef FFT_SCHED_CYCLE_CNT_EN
                    check("last_cycles", 32'(last_cycles), DONE_AT);
`endif
                end
            end
        end
    end

    task automatic settle_and_check_empty(input string name);
        for (int i = 0; i < 400 && done_q.size() > 0; i++) @(posedge clk);
        repeat (TOTAL_LAT + 4) @(posedge clk);
        #1;
        check(name, rd_q.size() + wr_q.size() + done_q.size(), 0);
    endtask

    initial begin
        // Reset with start held high: must be ignored.
        reset = 1'b1;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_outputs");
`ifdef FFT_SCHED_CYCLE_CNT_EN
        check("reset_last_cycles", 32'(last_cycles), 32'd0);
`endif
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("idle_after_reset", 32'({busy, rd_en, done}), 32'd0);

        // Full run with start pulses at cycles 5 and 50 that must be ignored.
        t0 = cyc;
        push_run(t0);
        start = 1'b1;
        for (int r = 1; r <= DONE_AT; r++) begin
            @(posedge clk);
            #1;
            start = (r == 5 || r == 50);
            if (r == 5 || r == 50) check("busy_at_ignored_start", 32'(busy), 32'd1);
            if (r == 22) check("last_s0_write", 32'({wr_en, rd_en}), 32'b10);
            if (r == 23) check("first_s1_read", 32'({wr_en, rd_en}), 32'b01);
            for (int i = 0; i < 5; i++) begin
                if (dir_tab[i][0] == r) begin
                    check("directed_rd", 32'({rd_en, rd_addr_a, rd_addr_b, tw_addr}),
                          32'({1'b1, 5'(dir_tab[i][1]), 5'(dir_tab[i][2]), 4'(dir_tab[i][3])}));
                end
            end
        end
        start = 1'b0;
        settle_and_check_empty("run1_drained");

        // Reset in the middle of stage 2 discards the transform.
        t0 = cyc;
        push_run(t0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2 * P + 5 - 1) @(posedge clk);
        #1;
        reset = 1'b1;
        rd_q.delete();
        wr_q.delete();
        done_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_all_zero("reset_mid_outputs");
        repeat (TOTAL_LAT + 4) @(posedge clk);
        #1;
        check("no_activity_after_reset", 32'({busy, rd_en, wr_en, done}), 32'd0);

        // Clean run with start held high: back-to-back restart at cycle DONE_AT+1.
        t0 = cyc;
        push_run(t0);
        push_run(t0 + DONE_AT + 1);
        start = 1'b1;
        repeat (DONE_AT + 2) @(posedge clk);
        #1;
        start = 1'b0;
        settle_and_check_empty("run3_drained");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
